// File: rtl/pcie_egress.sv
// pcie_egress: builds 3DW MRd/MWr TLPs onto a 32-bit AXI-Stream host port
module pcie_egress #(
   parameter int BUF_DEPTH_BITS = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_axi_egress_ready,
   output logic [31:0]               o_axi_egress_data,
   output logic [3:0]                o_axi_egress_keep,
   output logic                      o_axi_egress_last,
   output logic                      o_axi_egress_valid,
   input  logic                      i_en,
   input  logic                      i_cmd_write,
   input  logic [31:0]               i_addr,
   input  logic [9:0]                i_dword_count,
   input  logic [15:0]               i_requester_id,
   input  logic [7:0]                i_tag,
   output logic                      o_finished,
   output logic                      o_buf_rd_stb,
   output logic [BUF_DEPTH_BITS-1:0] o_buf_addr,
   input  logic [31:0]               i_buf_data,
   output logic [3:0]                o_state,
   output logic [7:0]                o_egress_count
);
   typedef enum logic [3:0] {
      IDLE = 4'd0, HDR0 = 4'd1, HDR1 = 4'd2, HDR2 = 4'd3, DATA = 4'd4, DONE = 4'd5
   } state_t;
   state_t state, state_nx;
   logic        r_write;
   logic [29:0] r_addr;
   logic [9:0]  r_len;
   logic [15:0] r_id;
   logic [7:0]  r_tag;
   logic [10:0] r_rd_count, r_data_count, total;
   logic [31:0] fifo_mem [2];
   logic        fifo_rp, fifo_wp, r_pending;
   logic [1:0]  fifo_count;
   logic        xfer, pop, start, fifo_nempty, in_tlp;
   logic [31:0] dw0, dw1, dw2;
   assign total       = (r_len == 10'd0) ? 11'd1024 : {1'b0, r_len};
   assign fifo_nempty = fifo_count != 2'd0;
   assign in_tlp      = state == HDR0 || state == HDR1 || state == HDR2 || state == DATA;
   assign xfer        = o_axi_egress_valid & i_axi_egress_ready;
   assign pop         = xfer & (state == DATA);
   assign start       = state == IDLE && i_en && !o_finished;
   assign dw0 = {1'b0, r_write, 1'b0, 19'd0, r_len};
   assign dw1 = {r_id, r_tag, (total > 11'd1) ? 4'hF : 4'h0, 4'hF};
   assign dw2 = {r_addr, 2'b00};
   // A slot freed by this cycle's pop counts as free, which keeps the payload bubble-free at full rate.
   assign o_buf_rd_stb = r_write && in_tlp && r_rd_count < total &&
                         ({1'b0, fifo_count} + {2'b0, r_pending} - {2'b0, pop}) < 3'd2;
   assign o_axi_egress_valid = (state == HDR0 || state == HDR1 || state == HDR2) ||
                               (state == DATA && fifo_nempty);
   assign o_axi_egress_data  = !o_axi_egress_valid ? 32'h0 :
                               state == HDR0 ? dw0 :
                               state == HDR1 ? dw1 :
                               state == HDR2 ? dw2 : fifo_mem[fifo_rp];
   assign o_axi_egress_keep  = o_axi_egress_valid ? 4'hF : 4'h0;
   assign o_axi_egress_last  = (state == HDR2 && !r_write) ||
                               (state == DATA && fifo_nempty && r_data_count == total - 11'd1);
   assign o_finished = state == DONE;
   assign o_state    = state;
   // Next-state logic: headers advance on transfer, payload ends on the Nth beat.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? HDR0 : IDLE;
         HDR0:    state_nx = xfer ? HDR1 : HDR0;
         HDR1:    state_nx = xfer ? HDR2 : HDR1;
         HDR2:    state_nx = xfer ? (r_write ? DATA : DONE) : HDR2;
         DATA:    state_nx = (pop && r_data_count == total - 11'd1) ? DONE : DATA;
         DONE:    state_nx = i_en ? DONE : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // State, command latch, counters and FIFO bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         r_write        <= 1'b0;
         r_addr         <= '0;
         r_len          <= '0;
         r_id           <= '0;
         r_tag          <= '0;
         r_rd_count     <= '0;
         r_data_count   <= '0;
         o_buf_addr     <= '0;
         r_pending      <= 1'b0;
         fifo_rp        <= 1'b0;
         fifo_wp        <= 1'b0;
         fifo_count     <= '0;
         o_egress_count <= '0;
      end else begin
         state      <= state_nx;
         r_pending  <= o_buf_rd_stb;
         fifo_count <= fifo_count + {1'b0, r_pending} - {1'b0, pop};
         if (start) begin
            r_write      <= i_cmd_write;
            r_addr       <= i_addr[31:2];
            r_len        <= i_dword_count;
            r_id         <= i_requester_id;
            r_tag        <= i_tag;
            r_rd_count   <= '0;
            r_data_count <= '0;
            o_buf_addr   <= '0;
         end
         if (o_buf_rd_stb) begin
            r_rd_count <= r_rd_count + 11'd1;
            o_buf_addr <= o_buf_addr + 1'b1;
         end
         if (r_pending) fifo_wp <= ~fifo_wp;
         if (pop) begin
            fifo_rp      <= ~fifo_rp;
            r_data_count <= r_data_count + 11'd1;
         end
         if (state != DONE && state_nx == DONE) o_egress_count <= o_egress_count + 8'd1;
      end
   end
   // Skid FIFO storage captures buffer data one cycle after each strobe.
   always_ff @(posedge clk) begin
      if (r_pending) fifo_mem[fifo_wp] <= i_buf_data;
   end
endmodule

// File: tb/tb_pcie_egress.sv
// tb_pcie_egress: scoreboard bench for the TLP egress transmitter
module tb_pcie_egress;
   logic        clk = 1'b0, rst = 1'b1, ready = 1'b1;
   logic [31:0] data;
   logic [3:0]  keep;
   logic        last, valid;
   logic        i_en = 1'b0, i_cmd_write = 1'b0;
   logic [31:0] i_addr = '0;
   logic [9:0]  i_dword_count = '0;
   logic [15:0] i_requester_id = '0;
   logic [7:0]  i_tag = '0;
   logic        o_finished, o_buf_rd_stb;
   logic [9:0]  o_buf_addr;
   logic [31:0] i_buf_data = '0;
   logic [3:0]  o_state;
   logic [7:0]  o_egress_count;

   pcie_egress #(.BUF_DEPTH_BITS(10)) dut (
      .clk(clk), .rst(rst), .i_axi_egress_ready(ready),
      .o_axi_egress_data(data), .o_axi_egress_keep(keep),
      .o_axi_egress_last(last), .o_axi_egress_valid(valid),
      .i_en(i_en), .i_cmd_write(i_cmd_write), .i_addr(i_addr),
      .i_dword_count(i_dword_count), .i_requester_id(i_requester_id), .i_tag(i_tag),
      .o_finished(o_finished), .o_buf_rd_stb(o_buf_rd_stb), .o_buf_addr(o_buf_addr),
      .i_buf_data(i_buf_data), .o_state(o_state), .o_egress_count(o_egress_count)
   );

   always #5 clk = ~clk;

   logic [32:0] sb[$];
   logic [31:0] buf_mem [1024];
   int          checks = 0, failures = 0;
   int          cyc = 0, last_cyc = -10, strobes = 0, pops = 0, exp_egress = 0;
   logic [9:0]  exp_addr = '0, addr_s = '0;
   logic        stb_s = 1'b0, stall_p = 1'b0;
   logic [32:0] stall_v = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Payload buffer model: one-cycle read latency.
   always @(posedge clk) i_buf_data <= stb_s ? buf_mem[addr_s] : 32'h0;

   // Monitor: strobes, scoreboard pops, stall stability, outstanding reads.
   always @(negedge clk) begin
      stb_s  = !rst && o_buf_rd_stb;
      addr_s = o_buf_addr;
      if (stb_s) begin
         chk("buf_addr", 64'(o_buf_addr), 64'(exp_addr));
         exp_addr = exp_addr + 10'd1;
         strobes++;
      end
      if (!rst && stall_p) chk("stall_hold", {31'd0, valid, last, data}, {31'd0, 1'b1, stall_v});
      if (!rst && valid) chk("keep", 64'(keep), 64'hF);
      if (!rst && valid && ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0h expected=none", {last, data});
         end else begin
            chk("beat", 64'({last, data}), 64'(sb.pop_front()));
         end
         if (last) last_cyc = cyc;
         if (o_state == 4'd4) pops++;
      end
      stall_p = !rst && valid && !ready;
      stall_v = {last, data};
      if (!rst && o_state == 4'd4) chk("outstanding_le2", 64'((strobes - pops) <= 2), 64'd1);
   end

   task automatic expect_tlp(input logic w, input int total, input logic [31:0] e0, e1, e2);
      sb.push_back({1'b0, e0});
      sb.push_back({1'b0, e1});
      sb.push_back({!w, e2});
      if (w) for (int i = 0; i < total; i++) sb.push_back({i == total - 1, buf_mem[i % 1024]});
      strobes  = 0;
      pops     = 0;
      exp_addr = '0;
   endtask

   task automatic send(input logic w, input logic [31:0] a, input logic [9:0] n,
                       input logic [15:0] id, input logic [7:0] tg, input logic tog,
                       input logic [31:0] e0, e1, e2);
      int total;
      int k;
      total = (n == 10'd0) ? 1024 : int'(n);
      expect_tlp(w, total, e0, e1, e2);
      i_cmd_write = w; i_addr = a; i_dword_count = n; i_requester_id = id; i_tag = tg;
      ready = 1'b1;
      i_en  = 1'b1;
      k = 0;
      do begin
         @(posedge clk); #1;
         if (tog) ready = ~ready;
         k++;
      end while (!o_finished && k < 3000);
      chk("finished", 64'(o_finished), 64'd1);
      chk("fin_latency", 64'(cyc), 64'(last_cyc + 1));
      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("strobes", 64'(strobes), 64'(w ? total : 0));
      exp_egress++;
      chk("egress_count", 64'(o_egress_count), 64'(exp_egress & 255));
      ready = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         chk("hold_finished", {58'd0, o_finished, valid, o_state}, {58'd0, 1'b1, 1'b0, 4'd5});
      end
      i_en = 1'b0;
      @(posedge clk); #1;
      chk("drop_en_idle", {59'd0, o_finished, o_state}, {59'd0, 1'b0, 4'd0});
   endtask

   initial begin
      int k;
      for (int i = 0; i < 1024; i++) buf_mem[i] = 32'hC000_0000 | i;
      buf_mem[0] = 32'hDEADBEEF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {data, keep, last, valid, o_finished, o_buf_rd_stb},
          {32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      chk("rst_misc", {o_buf_addr, o_state, o_egress_count}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      send(1'b0, 32'h10000004, 10'd16, 16'h0100, 8'h05, 1'b0,
           32'h00000010, 32'h010005FF, 32'h10000004);
      send(1'b1, 32'h20000000, 10'd1, 16'h0100, 8'h00, 1'b0,
           32'h40000001, 32'h0100000F, 32'h20000000);
      for (int i = 0; i < 4; i++) buf_mem[i] = 32'hA0 + i;
      send(1'b1, 32'h3000000B, 10'd4, 16'h0100, 8'h12, 1'b1,
           32'h40000004, 32'h010012FF, 32'h30000008);
      send(1'b1, 32'h40000000, 10'd0, 16'hABCD, 8'h7E, 1'b0,
           32'h40000000, 32'hABCD7EFF, 32'h40000000);
      expect_tlp(1'b1, 8, 32'h40000008, 32'h000101FF, 32'h50000000);
      i_cmd_write = 1'b1; i_addr = 32'h50000000; i_dword_count = 10'd8;
      i_requester_id = 16'h0001; i_tag = 8'h01; ready = 1'b1; i_en = 1'b1;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (o_state != 4'd4 && k < 50);
      chk("reached_data", 64'(o_state), 64'd4);
      @(posedge clk); #1;
      rst  = 1'b1;
      i_en = 1'b0;
      @(posedge clk); #1;
      chk("midrst_valid", 64'(valid), 64'd0);
      chk("midrst_state", 64'(o_state), 64'd0);
      chk("midrst_finished", 64'(o_finished), 64'd0);
      chk("midrst_outputs", {data, keep, last, o_buf_rd_stb, o_buf_addr, o_egress_count},
          {32'd0, 4'd0, 1'b0, 1'b0, 10'd0, 8'd0});
      sb.delete();
      rst = 1'b0;
      exp_egress = 0;
      @(posedge clk); #1;
      send(1'b0, 32'hFFFFFFFF, 10'd1, 16'h1234, 8'h9A, 1'b1,
           32'h00000001, 32'h12349A0F, 32'hFFFFFFFC);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
